serial_shift_reg: RTL and testbench

Parametrised bidirectional serial shift register with a built-in burst controller, the generalised operand register of the serial multiplier datapath. It parallel-loads a WIDTH-bit word and, on a START request, shifts exactly WIDTH bits out serially, left or right, while shifting SIN in. It reports BUSY, the shift count and a one-cycle DONE pulse to the multiplier sequencer.

---
 rtl/serial_shift_reg.sv | 79 +++++++
 tb/tb_serial_shift_reg.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_shift_reg.sv
// Bidirectional WIDTH-bit serial shift register with a START-triggered WIDTH-shift burst controller.
// Define SHIFTREG_ROTATE_EN to compile in recirculating (rotate) bursts selected by ROT.
module serial_shift_reg #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic             DIR,
    input  logic             SIN,
    input  logic             ROT,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CW-1:0]    CNT
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state;
    logic   dir_r;
    logic   rot_r;
    logic   fill;

`ifndef SHIFTREG_ROTATE_EN
    assign rot_r = 1'b0;
    logic unused_rot;
    assign unused_rot = ROT;
`endif

    assign SOUT = dir_r ? Q[0] : Q[WIDTH-1];
    // A rotate refills with the very bit leaving on SOUT, so a full burst restores Q.
    assign fill = rot_r ? SOUT : SIN;
    assign BUSY = (state == SHIFT);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            Q     <= '0;
            dir_r <= 1'b0;
`ifdef SHIFTREG_ROTATE_EN
            rot_r <= 1'b0;
`endif
            CNT   <= '0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        Q <= D;
                    end else if (START) begin
                        dir_r <= DIR;
`ifdef SHIFTREG_ROTATE_EN
                        rot_r <= ROT;
`endif
                        CNT   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (dir_r) Q <= {fill, Q[WIDTH-1:1]};
                    else       Q <= {Q[WIDTH-2:0], fill};
                    CNT <= CNT + CW'(1);
                    if (CNT == CW'(WIDTH - 1)) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_reg.sv
// Self-checking bench for serial_shift_reg: directed plan cases plus random bursts
// checked against a transaction-level model of the serial output stream and final word.
module tb_serial_shift_reg;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          CLK = 1'b0;
    logic          RST, LOAD, START, DIR, SIN, ROT;
    logic [W-1:0]  D;
    logic [W-1:0]  Q;
    logic          SOUT, BUSY, DONE;
    logic [CW-1:0] CNT;

    int n_chk  = 0;
    int n_pass = 0;

    serial_shift_reg #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .D(D), .START(START), .DIR(DIR),
        .SIN(SIN), .ROT(ROT), .Q(Q), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

`ifdef SHIFTREG_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected final word after a burst from the serial rules, not from per-edge shifting.
    function automatic logic [W-1:0] burst_final(input logic [W-1:0] pre, input logic dir,
                                                 input logic rot, input logic [W-1:0] s);
        logic [W-1:0] r;
        if (rot && ROT_EN) return pre;
        // Left: SIN of shift j lands at bit W-j. Right: it lands at bit j-1.
        for (int j = 0; j < W; j++) r[W-1-j] = s[j];
        return dir ? s : r;
    endfunction

    // Shift phase of a burst already accepted at the last edge; leaves the bench in the DONE cycle.
    task automatic shift_phase(input logic [W-1:0] pre, input logic dir, input logic rot,
                               input logic [W-1:0] s, input bit noise);
        chk("busy_start", BUSY, 1);
        chk("cnt_start", CNT, 0);
        chk("q_start", Q, pre);
        for (int i = 1; i <= W; i++) begin
            chk("sout", SOUT, dir ? pre[i-1] : pre[W-i]);
            SIN = s[i-1];
            START = noise ? 1'($urandom) : 1'b0;
            LOAD  = noise ? 1'($urandom) : 1'b0;
            D     = W'($urandom);
            DIR   = 1'($urandom);
            tick();
            chk("cnt", CNT, i);
            chk("busy", BUSY, (i < W));
            chk("done", DONE, (i == W));
        end
        LOAD = 1'b0; START = 1'b0;
        chk("q_final", Q, burst_final(pre, dir, rot, s));
    endtask

    task automatic run_burst(input logic [W-1:0] d, input logic dir, input logic rot,
                             input logic [W-1:0] s, input bit noise);
        LOAD = 1'b1; D = d; START = 1'b0;
        tick();
        chk("q_load", Q, d);
        LOAD = 1'b0; START = 1'b1; DIR = dir; ROT = rot;
        tick();
        START = 1'b0; ROT = 1'b0;
        shift_phase(d, dir, rot, s, noise);
    endtask

    initial begin
        logic [W-1:0] d, s, fin;
        logic dir, rot;
        RST = 1'b0; LOAD = 1'b0; START = 1'b0; DIR = 1'b0; SIN = 1'b0; ROT = 1'b0; D = '0;
        tick(); tick();
        RST = 1'b1;
        tick();

        // Reset while idle with Q full of ones
        LOAD = 1'b1; D = 4'hF;
        tick();
        LOAD = 1'b0;
        chk("q_pre_rst", Q, 4'hF);
        RST = 1'b0;
        tick();
        chk("rst_q", Q, 0);
        chk("rst_sout", SOUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_cnt", CNT, 0);
        RST = 1'b1;
        tick();

        run_burst(4'b1011, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("done_clear_pre", DONE, 1);
        tick();
        chk("done_clear", DONE, 0);
        chk("cnt_hold", CNT, W);

        run_burst(4'b0001, 1'b1, 1'b0, 4'b1111, 1'b0);

        // LOAD wins over START in the same idle cycle
        LOAD = 1'b1; START = 1'b1; D = 4'h6;
        tick();
        LOAD = 1'b0; START = 1'b0;
        chk("prio_busy", BUSY, 0);
        chk("prio_q", Q, 4'h6);
        tick();
        chk("prio_busy2", BUSY, 0);

        // Bursts with LOAD/START/DIR noise during SHIFT, then START in the DONE cycle
        run_burst(4'b1100, 1'b0, 1'b0, 4'b1010, 1'b1);
        fin = burst_final(4'b1100, 1'b0, 1'b0, 4'b1010);
        START = 1'b1; DIR = 1'b1; ROT = 1'b0;
        tick();
        START = 1'b0;
        shift_phase(fin, 1'b1, 1'b0, 4'b0110, 1'b1);

        run_burst(4'b1001, 1'b0, 1'b1, 4'b0000, 1'b0);

        // Reset two shifts into a burst
        LOAD = 1'b1; D = 4'hA;
        tick();
        LOAD = 1'b0; START = 1'b1; DIR = 1'b0;
        tick();
        START = 1'b0;
        tick(); tick();
        chk("mid_cnt", CNT, 2);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("mid_rst_q", Q, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_cnt", CNT, 0);
        tick();
        chk("mid_rst_done", DONE, 0);
        chk("mid_rst_busy2", BUSY, 0);

        for (int n = 0; n < 40; n++) begin
            d = W'($urandom); s = W'($urandom);
            dir = 1'($urandom); rot = 1'($urandom);
            run_burst(d, dir, rot, s, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
